// File: rtl/time_edit_pkg.sv
// time_edit_pkg -- shared types and defaults for the time editor.
//   state_t : editor FSM states
//   key_t   : decoded inc/dec key
//   DEF_*   : default moduli (24:60:60), reset time (08:00:00), repeat timing
//   rpt_cw  : repeat counter width for a given first-repeat delay
package time_edit_pkg;

  typedef enum logic {ST_IDLE, ST_EDIT} state_t;

  typedef enum logic [1:0] {KEY_NONE, KEY_INC, KEY_DEC} key_t;

  localparam logic [23:0] DEF_MOD      = {8'd24, 8'd60, 8'd60};
  localparam logic [23:0] DEF_RST_TIME = {8'd8, 8'd0, 8'd0};
  localparam int          DEF_RPT_DLY  = 500;
  localparam int          DEF_RPT_PER  = 100;

  function automatic int rpt_cw(input int dly);
    return $clog2(dly + 1);
  endfunction

  localparam int RPT_CW = rpt_cw(DEF_RPT_DLY);

endpackage

// File: rtl/time_field_step.sv
// time_field_step -- one modular time field with load, step and carry/borrow.
//   clk, rst       : clock, synchronous active-high reset (loads rst_val)
//   mod            : field modulus (>= 2); value is kept in [0, mod-1]
//   load/load_val  : snapshot, clamped to mod-1 if out of range
//   en, inc, dec   : local step request (en selects this field)
//   cin, bin       : carry/borrow from the next lower field
//   val            : registered field value
//   cout, bout     : this step wraps upward / downward
module time_field_step #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] mod,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  input  logic         cin,
  input  logic         bin,
  output logic [W-1:0] val,
  output logic         cout,
  output logic         bout
);

  logic [W-1:0] top_val;
  logic         at_max, at_zero, up, dn;

  assign top_val = mod - W'(1);
  assign at_max  = (val == top_val);
  assign at_zero = (val == '0);
  assign up      = (en & inc) | cin;
  assign dn      = (en & dec) | bin;
  assign cout    = up & at_max;
  assign bout    = dn & at_zero;

  always_ff @(posedge clk) begin
    if (rst)       val <= rst_val;
    else if (load) val <= (load_val >= mod) ? top_val : load_val;
    else if (up)   val <= at_max ? '0 : val + W'(1);
    else if (dn)   val <= at_zero ? top_val : val - W'(1);
  end

endmodule

// File: rtl/time_edit.sv
// time_edit -- multi-field time editor with cursor and held-key auto-repeat.
//   clk, rst      : clock, synchronous active-high reset
//   start         : snapshot cur_time and (re)enter edit
//   cur_time      : running time, field 0 = least significant
//   sel_next      : move cursor one field down (0 wraps to NF-1)
//   inc, dec      : debounced key levels
//   commit/cancel : leave edit, with or without commit_pulse
//   edit_time     : registered working value
//   cursor        : selected field
//   editing       : in EDIT state
//   modified      : a step happened since the last start
//   commit_pulse  : one-cycle strobe after commit
// Build option: TIME_EDIT_CARRY_EN ripples wraps into the next higher field.
// Assumes RPT_PER <= RPT_DLY so the repeat counter never leaves [0, RPT_DLY].
module time_edit
  import time_edit_pkg::*;
#(
  parameter int               NF       = 3,
  parameter int               W        = 8,
  parameter logic [NF*W-1:0]  MOD      = DEF_MOD,
  parameter logic [NF*W-1:0]  RST_TIME = DEF_RST_TIME,
  parameter int               RPT_DLY  = DEF_RPT_DLY,
  parameter int               RPT_PER  = DEF_RPT_PER,
  localparam int              CURW     = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NF-1:0][W-1:0]  cur_time,
  input  logic                  sel_next,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  commit,
  input  logic                  cancel,
  output logic [NF-1:0][W-1:0]  edit_time,
  output logic [CURW-1:0]       cursor,
  output logic                  editing,
  output logic                  modified,
  output logic                  commit_pulse
);

  localparam int          CW         = rpt_cw(RPT_DLY);
  localparam logic [CW-1:0] CNT_HIT    = CW'(RPT_DLY);
  // After a repeat step, restart so the next hit is RPT_PER cycles later.
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RPT_DLY - RPT_PER + 1);

  state_t        state_q, state_d;
  key_t          key, key_q;
  logic [CW-1:0] cnt;
  logic          in_edit, do_cancel, do_commit, do_start, do_sel, key_ok;
  logic          step, step_inc, step_dec;

  assign in_edit   = (state_q == ST_EDIT);
  assign do_cancel = in_edit & cancel;
  assign do_commit = in_edit & ~cancel & commit;
  assign do_start  = start & ~do_cancel & ~do_commit;
  assign do_sel    = in_edit & ~cancel & ~commit & ~start & sel_next;
  assign key_ok    = in_edit & ~cancel & ~commit & ~start & ~sel_next;

  always_comb begin
    key = KEY_NONE;
    if (inc & ~dec)      key = KEY_INC;
    else if (dec & ~inc) key = KEY_DEC;
  end

  // Step on the first active cycle of a key (including a direct inc<->dec
  // swap) and whenever the repeat counter reaches its hit value.
  assign step     = key_ok && (key != KEY_NONE) && ((key != key_q) || (cnt == CNT_HIT));
  assign step_inc = step && (key == KEY_INC);
  assign step_dec = step && (key == KEY_DEC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EDIT;
      ST_EDIT: if (cancel || commit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_q        <= KEY_NONE;
      cnt          <= '0;
      cursor       <= CURW'(NF - 1);
      modified     <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key;
      commit_pulse <= do_commit;

      if (do_start)    cursor <= CURW'(NF - 1);
      else if (do_sel) cursor <= (cursor == '0) ? CURW'(NF - 1) : cursor - CURW'(1);

      if (do_start || do_cancel) modified <= 1'b0;
      else if (step)             modified <= 1'b1;

      if (!key_ok || key == KEY_NONE) cnt <= '0;
      else if (key != key_q)          cnt <= CW'(1);
      else if (cnt == CNT_HIT)        cnt <= CNT_RELOAD;
      else                            cnt <= cnt + CW'(1);
    end
  end

  assign editing = in_edit;

  // Carry/borrow chain: cy[i]/bw[i] come out of field i-1.
  logic [NF:0]   cy, bw;
  logic [NF-1:0] cin, bin;

  assign cy[0] = 1'b0;
  assign bw[0] = 1'b0;

  for (genvar i = 0; i < NF; i++) begin : g_fld
    time_field_step #(.W(W)) u_fld (
      .clk      (clk),
      .rst      (rst),
      .rst_val  (RST_TIME[i*W +: W]),
      .mod      (MOD[i*W +: W]),
      .load     (do_start),
      .load_val (cur_time[i]),
      .en       (cursor == CURW'(i)),
      .inc      (step_inc),
      .dec      (step_dec),
      .cin      (cin[i]),
      .bin      (bin[i]),
      .val      (edit_time[i]),
      .cout     (cy[i+1]),
      .bout     (bw[i+1])
    );
`ifdef TIME_EDIT_CARRY_EN
    assign cin[i] = cy[i];
    assign bin[i] = bw[i];
`else
    assign cin[i] = 1'b0;
    assign bin[i] = 1'b0;
`endif
  end

  // Top-field carry out (and the whole chain without carry) goes nowhere.
  logic unused_cy;
  assign unused_cy = ^{cy, bw};

endmodule

// File: tb/tb_time_edit.sv
module tb_time_edit;

  logic        clk = 1'b0;
  logic        rst, start, sel_next, inc, dec, commit, cancel;
  logic [23:0] cur_time;
  logic [23:0] edit_time;
  logic [1:0]  cursor;
  logic        editing, modified, commit_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  time_edit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cur_time     (cur_time),
    .sel_next     (sel_next),
    .inc          (inc),
    .dec          (dec),
    .commit       (commit),
    .cancel       (cancel),
    .edit_time    (edit_time),
    .cursor       (cursor),
    .editing      (editing),
    .modified     (modified),
    .commit_pulse (commit_pulse)
  );

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; sel_next = 0; inc = 0; dec = 0; commit = 0; cancel = 0;
    cur_time = '0;
    tick(2);
    chk("rst_time",   edit_time,    hms(8, 0, 0));
    chk("rst_cursor", cursor,       2);
    chk("rst_edit",   editing,      0);
    chk("rst_mod",    modified,     0);
    chk("rst_pulse",  commit_pulse, 0);
    rst = 1'b0;

    // Snapshot 23:59:58
    cur_time = hms(23, 59, 58); start = 1; tick(); start = 0;
    chk("start_time",   edit_time, hms(23, 59, 58));
    chk("start_cursor", cursor,    2);
    chk("start_edit",   editing,   1);
    chk("start_mod",    modified,  0);

    // Re-start in EDIT with out-of-range fields clamps to 23:59:59
    cur_time = hms(30, 70, 99); start = 1; tick(); start = 0;
    chk("clamp_time", edit_time, hms(23, 59, 59));

    sel_next = 1; tick(); chk("sel_1", cursor, 1);
    tick();               chk("sel_0", cursor, 0);
    sel_next = 0;

    // inc at 59 on field 0
    inc = 1; tick(); inc = 0;
`ifdef TIME_EDIT_CARRY_EN
    chk("inc_wrap", edit_time, hms(0, 0, 0));
`else
    chk("inc_wrap", edit_time, hms(23, 59, 0));
`endif
    chk("inc_mod", modified, 1);
    tick();
    // dec at 0 on field 0: both builds land on 23:59:59
    dec = 1; tick(); dec = 0;
    chk("dec_wrap", edit_time, hms(23, 59, 59));
    tick();

    // Both keys held: no stepping
    cur_time = hms(10, 5, 30); start = 1; tick(); start = 0;
    inc = 1; dec = 1; tick(1000); inc = 0; dec = 0;
    chk("both_time", edit_time, hms(10, 5, 30));
    chk("both_mod",  modified,  0);

    // Held dec on field 1: steps at edges 0, 500, 600, 700
    sel_next = 1; tick(); sel_next = 0;
    chk("sel_min", cursor, 1);
    dec = 1; tick();
    chk("rpt_first", edit_time, hms(10, 4, 30));
    tick(699);
    chk("rpt_699", edit_time, hms(10, 2, 30));
    tick();
    chk("rpt_700", edit_time, hms(10, 1, 30));
    dec = 0; tick(5);
    chk("rpt_rel", edit_time, hms(10, 1, 30));
    chk("rpt_mod", modified, 1);

    // Edit to 12:34:56 and commit
    cur_time = hms(12, 34, 55); start = 1; tick(); start = 0;
    sel_next = 1; tick(2); sel_next = 0;
    inc = 1; tick(); inc = 0; tick();
    commit = 1; tick(); commit = 0;
    chk("cm_pulse", commit_pulse, 1);
    chk("cm_time",  edit_time,    hms(12, 34, 56));
    chk("cm_mod",   modified,     1);
    chk("cm_edit",  editing,      0);
    tick();
    chk("cm_pulse_end", commit_pulse, 0);

    // New edit, one step on hours, then cancel
    cur_time = hms(1, 2, 3); start = 1; tick(); start = 0;
    inc = 1; tick(); inc = 0;
    chk("cn_step", edit_time, hms(2, 2, 3));
    cancel = 1; tick(); cancel = 0;
    chk("cn_pulse", commit_pulse, 0);
    chk("cn_edit",  editing,      0);
    chk("cn_mod",   modified,     0);
    tick();
    chk("cn_pulse2", commit_pulse, 0);

    // Keys ignored in IDLE
    inc = 1; sel_next = 1; tick(3); inc = 0; sel_next = 0;
    chk("idle_time",   edit_time, hms(2, 2, 3));
    chk("idle_cursor", cursor,    2);

    // Cursor wraps from field 0 back to NF-1
    start = 1; tick(); start = 0;
    sel_next = 1; tick(3); sel_next = 0;
    chk("sel_wrap", cursor, 2);

    // Reset mid-repeat: hours 05 -> 07 after edges 0 and 500
    cur_time = hms(5, 5, 5); start = 1; tick(); start = 0;
    inc = 1; tick(550);
    chk("pre_rst", edit_time, hms(7, 5, 5));
    rst = 1; tick(); rst = 0;
    chk("mid_rst_time", edit_time, hms(8, 0, 0));
    chk("mid_rst_edit", editing,   0);
    chk("mid_rst_cur",  cursor,    2);
    chk("mid_rst_mod",  modified,  0);
    tick(100); inc = 0;
    chk("post_rst", edit_time, hms(8, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
